// File: rtl/cdb_arbiter_q.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_q
// Common-data-bus arbiter for the Tomasulo datapath. Each producer channel
// (ch0 = add/sub ALU, ch1 = ld/sd unit, higher = future units) writes results
// into a private FIFO. At most one buffered word per cycle is broadcast on a
// registered CDB word.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-low (0 = reset)
//   in_valid   per-channel result valid
//   in_data    per-channel result word, channel i at [i*DATA_W +: DATA_W]
//   in_ready   per-channel FIFO not full (registered)
//   cdb_stall  blocks new grants while high
//   cdb_valid  cdb_data carries a broadcast this cycle
//   cdb_data   broadcast word (zero when idle)
//   cdb_src    channel that produced cdb_data (holds when idle)
//   occ        per-channel FIFO occupancy, channel i at [i*OW +: OW]
//
// Build option: define CDB_RR_EN for round-robin arbitration. Without it,
// arbitration is fixed priority with the lowest channel index winning.
// -----------------------------------------------------------------------------
module cdb_arbiter_q #(
    parameter int  NUM_CH     = 2,
    parameter int  DATA_W     = 16,
    parameter int  FIFO_DEPTH = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     cdb_stall,
    output logic                     cdb_valid,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [CH_W-1:0]          cdb_src,
    output logic [NUM_CH*OW-1:0]     occ
);
    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam logic [OW-1:0] FULL_CNT = OW'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d    [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q [NUM_CH];
    logic [PW-1:0]     wr_ptr_d [NUM_CH];
    logic [PW-1:0]     rd_ptr_q [NUM_CH];
    logic [PW-1:0]     rd_ptr_d [NUM_CH];
    logic [OW-1:0]     count_q  [NUM_CH];
    logic [OW-1:0]     count_d  [NUM_CH];
    logic [NUM_CH-1:0] ready_q, ready_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [CH_W-1:0]   cdb_src_q, cdb_src_d;

    logic [NUM_CH-1:0] nonempty_s;
    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] pop_s;
    logic              grant_vld_s;
    logic              pop_en_s;
    logic [CH_W-1:0]   grant_idx_s;

`ifdef CDB_RR_EN
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [CH_W-1:0]   cand_s;

    // Channel index base+offset, wrapped into 0..NUM_CH-1 (offset <= NUM_CH).
    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end else begin
            sum = sum;
        end
        return CH_W'(sum);
    endfunction
`endif

    // Request vector: a channel requests the bus whenever its FIFO holds a word.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty_s[i] = (count_q[i] != {OW{1'b0}});
        end
    end

    // Arbiter: scan from the lowest-preference candidate up so the preferred one is written last.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {CH_W{1'b0}};
`ifdef CDB_RR_EN
        cand_s = {CH_W{1'b0}};
        for (int k = NUM_CH; k >= 1; k--) begin
            cand_s      = rr_idx(last_grant_q, k);
            grant_vld_s = grant_vld_s | nonempty_s[cand_s];
            grant_idx_s = nonempty_s[cand_s] ? cand_s : grant_idx_s;
        end
        last_grant_d = last_grant_q;
`else
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            grant_vld_s = grant_vld_s | nonempty_s[i];
            grant_idx_s = nonempty_s[i] ? CH_W'(i) : grant_idx_s;
        end
`endif
        pop_en_s = grant_vld_s & ~cdb_stall;
`ifdef CDB_RR_EN
        if (pop_en_s) begin
            last_grant_d = grant_idx_s;
        end else begin
            last_grant_d = last_grant_q;
        end
`endif
    end

    // FIFO next state: push on handshake, pop on grant; ready follows the next count.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            // ready_q is 0 while full, so a full FIFO never pushes in a popping cycle.
            push_s[i]   = in_valid[i] & ready_q[i];
            pop_s[i]    = pop_en_s & (grant_idx_s == CH_W'(i));
            if (push_s[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data[i*DATA_W +: DATA_W];
                wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i];
            end
            if (pop_s[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
            end else begin
                rd_ptr_d[i] = rd_ptr_q[i];
            end
            if (push_s[i] && !pop_s[i]) begin
                count_d[i] = count_q[i] + OW'(1);
            end else if (pop_s[i] && !push_s[i]) begin
                count_d[i] = count_q[i] - OW'(1);
            end else begin
                count_d[i] = count_q[i];
            end
            ready_d[i] = (count_d[i] != FULL_CNT);
        end
    end

    // Broadcast word: head of the granted FIFO, or an idle bus that keeps the last source.
    always_comb begin
        if (pop_en_s) begin
            cdb_valid_d = 1'b1;
            cdb_data_d  = mem_q[grant_idx_s][rd_ptr_q[grant_idx_s]];
            cdb_src_d   = grant_idx_s;
        end else begin
            cdb_valid_d = 1'b0;
            cdb_data_d  = {DATA_W{1'b0}};
            cdb_src_d   = cdb_src_q;
        end
    end

    // State registers; reset discards all buffered words and any pending broadcast.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_q[i][j] <= {DATA_W{1'b0}};
                end
                wr_ptr_q[i] <= {PW{1'b0}};
                rd_ptr_q[i] <= {PW{1'b0}};
                count_q[i]  <= {OW{1'b0}};
            end
            ready_q     <= {NUM_CH{1'b0}};
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= {DATA_W{1'b0}};
            cdb_src_q   <= {CH_W{1'b0}};
`ifdef CDB_RR_EN
            last_grant_q <= CH_W'(NUM_CH - 1);
`endif
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
`ifdef CDB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Occupancy export, packed per channel straight from the count registers.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            occ[i*OW +: OW] = count_q[i];
        end
    end

    assign in_ready  = ready_q;
    assign cdb_valid = cdb_valid_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter_q.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter_q
// Self-checking bench for cdb_arbiter_q (NUM_CH=2, DATA_W=16, FIFO_DEPTH=4).
// Producers are modelled as per-channel pending queues. A reference model keeps
// per-channel FIFO queues and the arbitration state. Each granted word is pushed
// to a scoreboard queue and popped when the DUT broadcast is compared.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter_q;
    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_ready;
    logic        cdb_stall;
    logic        cdb_valid;
    logic [15:0] cdb_data;
    logic [0:0]  cdb_src;
    logic [5:0]  occ;

    int total = 0;
    int bad   = 0;

    logic [15:0] pend0[$];
    logic [15:0] pend1[$];
    logic [15:0] mq0[$];
    logic [15:0] mq1[$];
    logic [16:0] sb[$];
    logic [1:0]  m_rdy;
    logic        m_last;
    logic        m_src;
    logic        exp_v;
    int          win0;
    int          win1;

    always #5 clock = ~clock;

    cdb_arbiter_q #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cdb_stall (cdb_stall),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .occ       (occ)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive producers, let the edge happen, advance the model, compare.
    task automatic tick();
        logic        g;
        logic        gv;
        logic [15:0] w;
        logic [16:0] e;
        in_valid[0]   = (pend0.size() != 0);
        in_valid[1]   = (pend1.size() != 0);
        in_data[15:0]  = in_valid[0] ? pend0[0] : 16'h0000;
        in_data[31:16] = in_valid[1] ? pend1[0] : 16'h0000;
        @(posedge clock);
        gv = 1'b0;
        g  = 1'b0;
        if (!reset) begin
            mq0.delete();
            mq1.delete();
            sb.delete();
            m_rdy  = 2'b00;
            m_last = 1'b1;
            m_src  = 1'b0;
        end else begin
            if (!cdb_stall && (mq0.size() != 0 || mq1.size() != 0)) begin
`ifdef CDB_RR_EN
                if (m_last == 1'b1) g = (mq0.size() != 0) ? 1'b0 : 1'b1;
                else                g = (mq1.size() != 0) ? 1'b1 : 1'b0;
`else
                g = (mq0.size() != 0) ? 1'b0 : 1'b1;
`endif
                m_last = g;
                gv     = 1'b1;
                w      = g ? mq1.pop_front() : mq0.pop_front();
                sb.push_back({g, w});
                m_src  = g;
            end
            if (in_valid[0] && m_rdy[0]) begin
                mq0.push_back(in_data[15:0]);
                pend0.delete(0);
            end
            if (in_valid[1] && m_rdy[1]) begin
                mq1.push_back(in_data[31:16]);
                pend1.delete(0);
            end
            m_rdy[0] = (mq0.size() != FIFO_DEPTH);
            m_rdy[1] = (mq1.size() != FIFO_DEPTH);
        end
        exp_v = gv;
        #1;
        check_val("cdb_valid", {31'd0, cdb_valid}, {31'd0, exp_v});
        check_val("cdb_src", {31'd0, cdb_src}, {31'd0, m_src});
        if (exp_v) begin
            e = sb.pop_front();
            check_val("cdb_data", {16'd0, cdb_data}, {16'd0, e[15:0]});
            check_val("sb_src", {31'd0, cdb_src}, {31'd0, e[16]});
        end else begin
            check_val("cdb_data_idle", {16'd0, cdb_data}, 32'd0);
        end
        check_val("in_ready", {30'd0, in_ready}, {30'd0, m_rdy});
        check_val("occ", {26'd0, occ}, {26'd0, 3'(mq1.size()), 3'(mq0.size())});
    endtask

    // Run until producers and model FIFOs are empty, bounded.
    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            if (pend0.size() != 0 || pend1.size() != 0 || mq0.size() != 0 || mq1.size() != 0) tick();
        end
        check_val("drain_left", 32'(pend0.size() + pend1.size() + mq0.size() + mq1.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cdb_stall = 1'b0; in_valid = 2'b00; in_data = 32'd0;
        m_rdy = 2'b00; m_last = 1'b1; m_src = 1'b0; exp_v = 1'b0;

        // Reset held two cycles with both producers asserting valid.
        pend0.push_back(16'hDEAD);
        pend1.push_back(16'hBEEF);
        tick();
        tick();
        check_val("rst_valid", {31'd0, cdb_valid}, 32'd0);
        check_val("rst_data", {16'd0, cdb_data}, 32'd0);
        check_val("rst_occ", {26'd0, occ}, 32'd0);
        check_val("rst_ready", {30'd0, in_ready}, 32'd0);
        pend0.delete();
        pend1.delete();
        reset = 1'b1;
        tick();
        check_val("ready_after_rst", {30'd0, in_ready}, 32'd3);

        // Single word on ch1: broadcast after the second edge, for one cycle.
        pend1.push_back(16'h1234);
        tick();
        check_val("lat_early", {31'd0, cdb_valid}, 32'd0);
        tick();
        check_val("lat_valid", {31'd0, cdb_valid}, 32'd1);
        check_val("lat_data", {16'd0, cdb_data}, 32'h1234);
        check_val("lat_src", {31'd0, cdb_src}, 32'd1);
        tick();
        check_val("lat_once", {31'd0, cdb_valid}, 32'd0);

        // Contention: both channels push at the same edge, ch0 goes first.
        pend0.push_back(16'hA001);
        pend1.push_back(16'hB002);
        tick();
        tick();
        check_val("cont_a_data", {16'd0, cdb_data}, 32'hA001);
        check_val("cont_a_src", {31'd0, cdb_src}, 32'd0);
        tick();
        check_val("cont_b_data", {16'd0, cdb_data}, 32'hB002);
        check_val("cont_b_src", {31'd0, cdb_src}, 32'd1);
        tick();

        // Both channels always busy: fixed priority starves ch1, RR alternates.
        win0 = 0;
        win1 = 0;
        for (int c = 0; c < 12; c++) begin
            if (pend0.size() == 0) pend0.push_back(16'h0100 + 16'(c));
            if (pend1.size() == 0) pend1.push_back(16'h0200 + 16'(c));
            tick();
            if (cdb_valid === 1'b1) begin
                if (cdb_src === 1'b1) win1++;
                else                  win0++;
            end
        end
`ifdef CDB_RR_EN
        check_val("busy_ch0", 32'(win0), 32'd6);
        check_val("busy_ch1", 32'(win1), 32'd5);
`else
        check_val("busy_ch0", 32'(win0), 32'd11);
        check_val("busy_ch1", 32'(win1), 32'd0);
`endif
        drain();

        // Fill ch0 under stall: fifth word held by the producer until space frees.
        cdb_stall = 1'b1;
        for (int w = 0; w < 5; w++) pend0.push_back(16'hC000 + 16'(w));
        for (int c = 0; c < 4; c++) tick();
        check_val("full_occ0", {29'd0, occ[2:0]}, 32'd4);
        check_val("full_rdy0", {31'd0, in_ready[0]}, 32'd0);
        tick();
        check_val("full_hold_occ0", {29'd0, occ[2:0]}, 32'd4);
        cdb_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("fill_valid", {31'd0, cdb_valid}, 32'd1);
            check_val("fill_order", {16'd0, cdb_data}, 32'hC000 + 32'(k));
        end
        drain();

        // Stall for two cycles after the first of three ch1 broadcasts.
        pend1.push_back(16'hD000);
        pend1.push_back(16'hD001);
        pend1.push_back(16'hD002);
        tick();
        tick();
        check_val("ms_first", {16'd0, cdb_data}, 32'hD000);
        cdb_stall = 1'b1;
        tick();
        check_val("ms_stall1", {31'd0, cdb_valid}, 32'd0);
        tick();
        check_val("ms_stall2", {31'd0, cdb_valid}, 32'd0);
        cdb_stall = 1'b0;
        tick();
        check_val("ms_second", {16'd0, cdb_data}, 32'hD001);
        tick();
        check_val("ms_third", {16'd0, cdb_data}, 32'hD002);
        tick();
        check_val("ms_done", {31'd0, cdb_valid}, 32'd0);

        // Reset mid-operation with three words buffered.
        cdb_stall = 1'b1;
        pend1.push_back(16'hE000);
        pend1.push_back(16'hE001);
        pend1.push_back(16'hE002);
        for (int c = 0; c < 3; c++) tick();
        check_val("mid_occ1", {29'd0, occ[5:3]}, 32'd3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cdb_stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("mid_novalid", {31'd0, cdb_valid}, 32'd0);
        end
        check_val("mid_occ", {26'd0, occ}, 32'd0);
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
